raster_pixel_receiver: RTL

//  Far end of the rasterizer output link. Deserialises the three 16-bit serial lanes (PX, PY, C),

---
 rtl/raster_pixel_receiver_pkg.sv | 21 ++
 rtl/raster_pixel_receiver_sipo_lane.sv | 46 ++++
 rtl/raster_pixel_receiver.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/raster_pixel_receiver_pkg.sv
// Shared definitions for the raster pixel receiver.
// Holds the default lane/framebuffer geometry, the Q10.6 unit constant and
// the receiver state encoding used by the top-level FSM.
package raster_pixel_receiver_pkg;

    localparam int RPR_W      = 16;
    localparam int RPR_FRAC   = 6;
    localparam int RPR_FB_W   = 320;
    localparam int RPR_FB_H   = 240;
    localparam int RPR_ADDR_W = 17;

    // One whole pixel expressed in Q10.6 units.
    localparam int ONE_PIX = 1 << RPR_FRAC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } rprState_e;

endpackage

// File: rtl/raster_pixel_receiver_sipo_lane.sv
// rpr_sipo_lane: W-bit MSB-first serial-to-parallel shift register.
// Ports:
//   CLK      clock
//   RST      asynchronous active-high reset, clears the word
//   load_i   start of a new word: discard contents, capture bit_i as the MSB
//   shift_i  shift bit_i in at the LSB end
//   bit_i    serial lane input
//   word_o   assembled word; complete after one load and W-1 shifts
module rpr_sipo_lane
    import raster_pixel_receiver_pkg::*;
#(
    parameter int W = RPR_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         bit_i,
    output logic [W-1:0] word_o
);

    logic [W-1:0] word_q;
    logic [W-1:0] word_d;

    // A load restarts the word so a mid-word strobe cannot leave stale
    // bits behind; the MSB then walks up to bit W-1 over the next W-1 shifts.
    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = {{(W-1){1'b0}}, bit_i};
        end else if (shift_i) begin
            word_d = {word_q[W-2:0], bit_i};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/raster_pixel_receiver.sv
// raster_pixel_receiver: far end of the rasterizer output link.
// Deserialises the PX/PY/C lanes, converts Q10.6 coordinates to a linear
// framebuffer address and writes every in-triangle, on-screen pixel.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   STRB            marks the MSB cycle of a word on all three lanes
//   PX, PY, C       serial x, y (Q10.6 signed) and colour, MSB first
//   VALID           sampled with STRB: pixel lies inside the triangle
//   DONE            rasterizer finished the current triangle
//   FB_WE           framebuffer write strobe (one cycle)
//   FB_ADDR         y_int*FB_W + x_int, held between writes
//   FB_WDATA        colour, held between writes
//   TRI_DONE        one-cycle pulse once a triangle is fully committed
//   TRI_PIX         writes issued for the last triangle
//   CLIP_CNT        saturating count of valid pixels dropped off-screen
//   FRAME_ERR       sticky: a strobe arrived in the middle of a word
module raster_pixel_receiver
    import raster_pixel_receiver_pkg::*;
#(
    parameter int W      = RPR_W,
    parameter int FRAC   = RPR_FRAC,
    parameter int FB_W   = RPR_FB_W,
    parameter int FB_H   = RPR_FB_H,
    parameter int ADDR_W = RPR_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STRB,
    input  logic              PX,
    input  logic              PY,
    input  logic              C,
    input  logic              VALID,
    input  logic              DONE,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [W-1:0]      FB_WDATA,
    output logic              TRI_DONE,
    output logic [ADDR_W-1:0] TRI_PIX,
    output logic [15:0]       CLIP_CNT,
    output logic              FRAME_ERR
);

    localparam int                 CNT_W      = $clog2(W);
    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(W - 1);
    localparam logic signed [W-1:0] X_LIM     = W'(FB_W);
    localparam logic signed [W-1:0] Y_LIM     = W'(FB_H);
    localparam logic [ADDR_W-1:0]  ROW_STRIDE = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0]  PIX_MAX    = '1;
    localparam logic [15:0]        CLIP_MAX   = 16'hFFFF;

    rprState_e          state_q, state_d;
    logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic               vld_q, vld_d;
    logic               pendDone_q, pendDone_d;
    logic               doneFire_q, doneFire_d;
    logic [ADDR_W-1:0]  pixCnt_q, pixCnt_d;
    logic               fbWe_q, fbWe_d;
    logic [ADDR_W-1:0]  fbAddr_q, fbAddr_d;
    logic [W-1:0]       fbWdata_q, fbWdata_d;
    logic               triDone_q, triDone_d;
    logic [ADDR_W-1:0]  triPix_q, triPix_d;
    logic [15:0]        clipCnt_q, clipCnt_d;
    logic               frameErr_q, frameErr_d;

    logic               laneShift;
    logic [W-1:0]       pxWord, pyWord, cWord;
    logic signed [W-1:0] xInt, yInt;
    logic               onScreen;
    logic [ADDR_W-1:0]  pixAddr;
    logic               fireNow;

    // Every strobe (re)starts all three lanes; shifting only happens while
    // a word is being assembled so the word stays stable through COMMIT.
    assign laneShift = (state_q == SHIFT) && !STRB;

    rpr_sipo_lane #(.W(W)) uLanePx (
        .CLK(CLK), .RST(RST), .load_i(STRB), .shift_i(laneShift),
        .bit_i(PX), .word_o(pxWord)
    );

    rpr_sipo_lane #(.W(W)) uLanePy (
        .CLK(CLK), .RST(RST), .load_i(STRB), .shift_i(laneShift),
        .bit_i(PY), .word_o(pyWord)
    );

    rpr_sipo_lane #(.W(W)) uLaneC (
        .CLK(CLK), .RST(RST), .load_i(STRB), .shift_i(laneShift),
        .bit_i(C), .word_o(cWord)
    );

    // Integer pixel position (floor, arithmetic shift keeps negatives
    // negative) and its linear address; the address is only meaningful
    // when the pixel is on-screen, where it cannot overflow ADDR_W.
    assign xInt     = $signed(pxWord) >>> FRAC;
    assign yInt     = $signed(pyWord) >>> FRAC;
    assign onScreen = !xInt[W-1] && (xInt < X_LIM) && !yInt[W-1] && (yInt < Y_LIM);
    assign pixAddr  = ADDR_W'(yInt) * ROW_STRIDE + ADDR_W'(xInt);

    // A triangle is closed either directly by DONE while idle, or one cycle
    // after the COMMIT of the word that was in flight when DONE arrived.
    assign fireNow = doneFire_q || ((state_q == IDLE) && DONE && !STRB);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a strobe always lands in SHIFT (including the
    // back-to-back case out of COMMIT and the restart case inside SHIFT).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (STRB) state_d = SHIFT;
            SHIFT:   if (!STRB && (bitCnt_q == LAST_BIT)) state_d = COMMIT;
            COMMIT:  state_d = STRB ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values: bit counting, pixel commit,
    // clip/pixel counters, frame error and triangle completion.
    always_comb begin
        bitCnt_d   = bitCnt_q;
        vld_d      = vld_q;
        pendDone_d = pendDone_q;
        doneFire_d = 1'b0;
        pixCnt_d   = pixCnt_q;
        fbWe_d     = 1'b0;
        fbAddr_d   = fbAddr_q;
        fbWdata_d  = fbWdata_q;
        triDone_d  = 1'b0;
        triPix_d   = triPix_q;
        clipCnt_d  = clipCnt_q;
        frameErr_d = frameErr_q;

        if (STRB) begin
            bitCnt_d = CNT_W'(1);
            vld_d    = VALID;
        end else if (state_q == SHIFT) begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (DONE && STRB) pendDone_d = 1'b1;
            end
            SHIFT: begin
                if (STRB) frameErr_d = 1'b1;
                if (DONE) pendDone_d = 1'b1;
            end
            COMMIT: begin
                if (vld_q) begin
                    if (onScreen) begin
                        fbWe_d    = 1'b1;
                        fbAddr_d  = pixAddr;
                        fbWdata_d = cWord;
                        if (pixCnt_q != PIX_MAX) pixCnt_d = pixCnt_q + ADDR_W'(1);
                    end else if (clipCnt_q != CLIP_MAX) begin
                        clipCnt_d = clipCnt_q + 16'd1;
                    end
                end
                // A DONE arriving with a back-to-back strobe belongs to the
                // new word; otherwise it closes the word being committed.
                doneFire_d = pendDone_q || (DONE && !STRB);
                pendDone_d = DONE && STRB;
            end
            default: ;
        endcase

        // Never coincides with COMMIT, so no write can race the snapshot.
        if (fireNow) begin
            triDone_d = 1'b1;
            triPix_d  = pixCnt_q;
            pixCnt_d  = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bitCnt_q   <= '0;
            vld_q      <= 1'b0;
            pendDone_q <= 1'b0;
            doneFire_q <= 1'b0;
            pixCnt_q   <= '0;
            fbWe_q     <= 1'b0;
            fbAddr_q   <= '0;
            fbWdata_q  <= '0;
            triDone_q  <= 1'b0;
            triPix_q   <= '0;
            clipCnt_q  <= '0;
            frameErr_q <= 1'b0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            vld_q      <= vld_d;
            pendDone_q <= pendDone_d;
            doneFire_q <= doneFire_d;
            pixCnt_q   <= pixCnt_d;
            fbWe_q     <= fbWe_d;
            fbAddr_q   <= fbAddr_d;
            fbWdata_q  <= fbWdata_d;
            triDone_q  <= triDone_d;
            triPix_q   <= triPix_d;
            clipCnt_q  <= clipCnt_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign FB_WE     = fbWe_q;
    assign FB_ADDR   = fbAddr_q;
    assign FB_WDATA  = fbWdata_q;
    assign TRI_DONE  = triDone_q;
    assign TRI_PIX   = triPix_q;
    assign CLIP_CNT  = clipCnt_q;
    assign FRAME_ERR = frameErr_q;

endmodule
